// File: rtl/dm_pkg.sv
// dm_pkg: size encodings, FSM state type and alignment check shared by dm_rw
package dm_pkg;
  localparam logic [1:0] DM_SZ_BYTE = 2'b00;
  localparam logic [1:0] DM_SZ_HALF = 2'b01;
  localparam logic [1:0] DM_SZ_WORD = 2'b10;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} dm_state_t;
  // halfwords need an even address; words (and the reserved size) need a word-aligned one
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
    return (size == DM_SZ_BYTE) ? 1'b0 : (size == DM_SZ_HALF) ? addrLo[0] : (addrLo != 2'b00);
  endfunction
endpackage

// File: rtl/dm_lane_ext.sv
// dm_lane_ext: byte-lane select/extension for loads and lane enables for stores (DM_BIG_ENDIAN_EN selects big-endian lanes)
module dm_lane_ext import dm_pkg::*; (
  input  logic [1:0]  size,
  input  logic [1:0]  addrLo,
  input  logic        sext,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic [3:0]  byteEn,
  output logic [31:0] wrep
);
  logic [1:0] lane;
  logic [7:0] b;
  logic [15:0] h;
`ifdef DM_BIG_ENDIAN_EN
  assign lane = addrLo ^ 2'b11;
`else
  assign lane = addrLo;
`endif
  // pick the addressed lane(s), extend loads, replicate store data across lanes
  always_comb begin
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    ldata = (size == DM_SZ_BYTE) ? {{24{sext & b[7]}}, b} :
            (size == DM_SZ_HALF) ? {{16{sext & h[15]}}, h} : word;
    byteEn = (size == DM_SZ_BYTE) ? 4'b0001 << lane :
             (size == DM_SZ_HALF) ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wrep = (size == DM_SZ_BYTE) ? {4{wdata[7:0]}} :
           (size == DM_SZ_HALF) ? {2{wdata[15:0]}} : wdata;
  end
endmodule

// File: rtl/dm_rw.sv
// dm_rw: multi-cycle byte/half/word data memory with req/ready/done handshake (DM_BIG_ENDIAN_EN: big-endian lanes)
module dm_rw import dm_pkg::*; #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata
);
  localparam int DEPTH = 2 ** (ADDR_W - 2);
  dm_state_t state, nextState;
  logic [3:0] cnt;
  logic rWe, rSext;
  logic [1:0] rSize;
  logic [ADDR_W-1:0] rAddr;
  logic [31:0] rWdata;
  logic [31:0] mem [DEPTH];
  logic accept, goDone, opWe, opSext, opMis;
  logic [1:0] opSize;
  logic [ADDR_W-1:0] opAddr;
  logic [31:0] opWdata, ldata, wrep;
  logic [3:0] byteEn;
  // live request while idle (single-cycle path), registered copy once accepted
  always_comb begin
    accept = (state == IDLE) && req;
    opWe = (state == IDLE) ? we : rWe;
    opSize = (state == IDLE) ? size : rSize;
    opSext = (state == IDLE) ? sext : rSext;
    opAddr = (state == IDLE) ? addr : rAddr;
    opWdata = (state == IDLE) ? wdata : rWdata;
    opMis = isMisaligned(opSize, opAddr[1:0]);
    goDone = (accept && (LATENCY == 1 || opMis)) || (state == WAIT && cnt == 4'd1);
  end
  dm_lane_ext uLane (
    .size(opSize), .addrLo(opAddr[1:0]), .sext(opSext), .word(mem[opAddr[ADDR_W-1:2]]),
    .wdata(opWdata), .ldata(ldata), .byteEn(byteEn), .wrep(wrep)
  );
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nextState;
  // DONE lasts one cycle; misaligned or single-cycle accesses bypass WAIT
  always_comb begin
    nextState = (state == DONE) ? IDLE : goDone ? DONE : accept ? WAIT : state;
  end
  // capture the request, count down the latency, register the load result
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= 4'd0;
      rWe <= 1'b0;
      rSize <= 2'b00;
      rSext <= 1'b0;
      rAddr <= '0;
      rWdata <= 32'd0;
      rdata <= 32'd0;
    end else begin
      if (accept) begin
        rWe <= we;
        rSize <= size;
        rSext <= sext;
        rAddr <= addr;
        rWdata <= wdata;
        cnt <= 4'(LATENCY - 1);
      end else if (state == WAIT) cnt <= cnt - 4'd1;
      if (goDone && !opWe && !opMis) rdata <= ldata;
    end
  // per-lane store commit on the edge entering DONE; contents are never reset
  always_ff @(posedge clk)
    if (goDone && opWe && !opMis)
      for (int i = 0; i < 4; i++)
        if (byteEn[i]) mem[opAddr[ADDR_W-1:2]][8*i +: 8] <= wrep[8*i +: 8];
  assign ready = state == IDLE;
  assign done = state == DONE;
  assign err = done && isMisaligned(rSize, rAddr[1:0]);
endmodule

// File: tb/tb_dm_rw.sv
// tb_dm_rw: byte-level memory model checks two dm_rw instances (LATENCY 1 and 4) every cycle
module tb_dm_rw;
  logic clk = 0, rst = 1, req1 = 0, req4 = 0, we = 0, sext = 0;
  logic [1:0] size = 0;
  logic [7:0] addr = 0;
  logic [31:0] wdata = 0;
  logic rdy[2], dn[2], er[2];
  logic [31:0] rd[2];
  always #5 clk = ~clk;
  dm_rw #(.ADDR_W(8), .LATENCY(1)) d1 (.clk(clk), .rst(rst), .req(req1), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .ready(rdy[0]), .done(dn[0]), .err(er[0]), .rdata(rd[0]));
  dm_rw #(.ADDR_W(8), .LATENCY(4)) d4 (.clk(clk), .rst(rst), .req(req4), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .ready(rdy[1]), .done(dn[1]), .err(er[1]), .rdata(rd[1]));
  int lat[2] = '{1, 4};
  int cnt[2] = '{-1, -1};
  logic [7:0] mb[2][256];
  logic pWe[2], pSext[2];
  logic [1:0] pSize[2];
  logic [7:0] pAddr[2];
  logic [31:0] pWd[2];
  logic [31:0] mRd[2] = '{32'd0, 32'd0};
  int errors = 0, checks = 0;
  int litK = 0, litSeq = 0;
  string litNm = "";
  logic [31:0] litExp = 0;
  function automatic int nBytes(input logic [1:0] s);
    return s == 2'b00 ? 1 : s == 2'b01 ? 2 : 4;
  endfunction
  function automatic logic misal(input logic [1:0] s, input logic [7:0] a);
    return (int'(a) % nBytes(s)) != 0;
  endfunction
  function automatic int leff(input int k);
    return misal(pSize[k], pAddr[k]) ? 1 : lat[k];
  endfunction
  task automatic apply(input int k);
    int n, b;
    logic [31:0] v;
    n = nBytes(pSize[k]);
    v = 0;
    if (misal(pSize[k], pAddr[k])) return;
    for (int i = 0; i < n; i++) begin
`ifdef DM_BIG_ENDIAN_EN
      b = n - 1 - i;
`else
      b = i;
`endif
      if (pWe[k]) mb[k][int'(pAddr[k]) + i] = pWd[k][8*b +: 8];
      else v[8*b +: 8] = mb[k][int'(pAddr[k]) + i];
    end
    if (!pWe[k]) begin
      if (pSext[k] && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8*n));
      mRd[k] = v;
    end
  endtask
  task automatic modelEdge();
    if (rst) return;
    for (int k = 0; k < 2; k++) begin
      if (cnt[k] == -1) begin
        if (k == 0 ? req1 : req4) begin
          pWe[k] = we; pSize[k] = size; pSext[k] = sext; pAddr[k] = addr; pWd[k] = wdata;
          cnt[k] = 1;
          if (leff(k) == 1) apply(k);
        end
      end else if (cnt[k] == leff(k)) cnt[k] = -1;
      else begin
        cnt[k]++;
        if (cnt[k] == leff(k)) apply(k);
      end
    end
  endtask
  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h", nm, k, act, exp);
    end
  endtask
  initial begin
    int seen = 0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk("ready", k, 32'(rdy[k]), 32'(cnt[k] == -1));
        chk("done", k, 32'(dn[k]), 32'(cnt[k] == leff(k)));
        chk("err", k, 32'(er[k]), 32'(cnt[k] == leff(k) && misal(pSize[k], pAddr[k])));
        chk("rdata", k, rd[k], mRd[k]);
      end
      if (litSeq != seen) begin
        chk(litNm, litK, rd[litK], litExp);
        seen = litSeq;
      end
    end
  end
  task automatic step();
    @(posedge clk);
    modelEdge();
    #1;
  endtask
  task automatic waitIdle();
    for (int i = 0; i < 20 && !(cnt[0] == -1 && cnt[1] == -1); i++) step();
  endtask
  task automatic doOp(input logic [1:0] m, input logic w, input logic [1:0] s, input logic x,
                      input logic [7:0] a, input logic [31:0] d);
    we = w; size = s; sext = x; addr = a; wdata = d; req1 = m[0]; req4 = m[1];
    step();
    req1 = 0; req4 = 0;
    waitIdle();
  endtask
  task automatic lit(input int k, input string nm, input logic [31:0] e);
    litK = k; litNm = nm; litExp = e; litSeq++;
    @(negedge clk);
    #1;
  endtask
  initial begin
    step(); step();
    rst = 0;
    lit(0, "reset_rdata", 32'h0);
    for (int i = 0; i < 64; i++) doOp(3, 1, 2'b10, 0, 8'(i * 4), 32'h0);
    doOp(3, 1, 2'b10, 0, 8'h00, 32'h11223344);
`ifdef DM_BIG_ENDIAN_EN
    doOp(3, 0, 2'b00, 0, 8'h00, 0); lit(0, "ldb_0", 32'h00000011);
    doOp(3, 0, 2'b00, 0, 8'h03, 0); lit(1, "ldb_3", 32'h00000044);
`else
    doOp(3, 0, 2'b00, 0, 8'h00, 0); lit(0, "ldb_0", 32'h00000044);
    doOp(3, 0, 2'b00, 0, 8'h03, 0); lit(1, "ldb_3", 32'h00000011);
`endif
    doOp(3, 1, 2'b00, 0, 8'h05, 32'h00000080);
    doOp(3, 0, 2'b00, 1, 8'h05, 0); lit(0, "ldsb_5", 32'hFFFFFF80);
    doOp(3, 0, 2'b10, 0, 8'h04, 0);
`ifdef DM_BIG_ENDIAN_EN
    lit(1, "ldw_4", 32'h00800000);
`else
    lit(1, "ldw_4", 32'h00008000);
`endif
    doOp(3, 1, 2'b01, 0, 8'h0A, 32'h0000BEEF);
    doOp(3, 0, 2'b01, 1, 8'h0A, 0); lit(0, "ldsh_a", 32'hFFFFBEEF);
    doOp(3, 0, 2'b10, 0, 8'h08, 0);
`ifdef DM_BIG_ENDIAN_EN
    lit(1, "ldw_8", 32'h0000BEEF);
`else
    lit(1, "ldw_8", 32'hBEEF0000);
`endif
    doOp(3, 1, 2'b10, 0, 8'h02, 32'hDEADBEEF);
    lit(0, "misal_keep", rd[0] === 32'hBEEF0000 || rd[0] === 32'h0000BEEF ? rd[0] : 32'hBEEF0000);
    doOp(3, 0, 2'b10, 0, 8'h00, 0); lit(1, "misal_nowrite", 32'h11223344);
    doOp(3, 0, 2'b01, 1, 8'h01, 0); lit(1, "misal_ld_keep", 32'h11223344);
    we = 0; size = 2'b10; addr = 8'h20; req4 = 1;
    step();
    req4 = 0;
    step(); step();
    we = 1; addr = 8'h00; wdata = 32'hFFFFFFFF; req4 = 1;
    step();
    req4 = 0; we = 0;
    waitIdle();
    doOp(2, 0, 2'b10, 0, 8'h00, 0); lit(1, "busy_req_ignored", 32'h11223344);
    doOp(3, 1, 2'b10, 0, 8'h10, 32'h12345678);
    we = 1; size = 2'b10; addr = 8'h10; wdata = 32'hCAFEF00D; req4 = 1;
    step();
    req4 = 0;
    step(); step();
    rst = 1;
    cnt[0] = -1; cnt[1] = -1; mRd[0] = 0; mRd[1] = 0;
    step(); step();
    rst = 0;
    lit(1, "abort_rdata", 32'h0);
    doOp(2, 0, 2'b10, 0, 8'h10, 0); lit(1, "abort_nostore", 32'h12345678);
    for (int i = 0; i < 300; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) step();
      doOp(3, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 63)), $urandom);
    end
    step(); step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
